// File: rtl/i2c_master_arbiter.sv
// Round-robin two-port arbiter for one byte-level I2C engine: grant one cycle after a request, command after BUS_FREE_CYC free-bus
// cycles, response one cycle after eng_done. Requesters hold req_valid until rsp_done. I2C_ARB_TIMEOUT_EN enables the engine watchdog.
module i2c_master_arbiter #(
  parameter int BUS_FREE_CYC = 250,
  parameter int TIMEOUT_CYC  = 2_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_rw,
  input  logic [13:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  rsp_done,
  output logic        rsp_err,
  output logic [7:0]  rsp_rdata,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        eng_start,
  output logic        eng_rw,
  output logic [6:0]  eng_addr,
  output logic [7:0]  eng_wdata,
  input  logic        eng_done,
  input  logic        eng_ack_err,
  input  logic [7:0]  eng_rdata,
  output logic        eng_abort
);
  localparam int FW = $clog2(BUS_FREE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef I2C_ARB_TIMEOUT_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, BUS_WAIT, ISSUE, WAIT_DONE, RESPOND} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] free_cnt;
  logic [TW-1:0] wd_cnt;
  logic          owner, last_served, pick, bus_free, timeout, res_err;
  logic [1:0]    owner_oh;
  logic [7:0]    res_rdata;

  assign bus_free = scl_in & sda_in;
  // On a tie the port that was not served last wins.
  assign pick     = (req_valid == 2'b11) ? ~last_served : req_valid[1];
  assign owner_oh = {owner, ~owner};
  assign timeout  = WDOG_EN && (state == WAIT_DONE) && !eng_done &&
                    (wd_cnt == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nxt = state;
    gnt       = 2'b00;
    rsp_done  = 2'b00;
    rsp_err   = 1'b0;
    rsp_rdata = 8'h00;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    case (state)
      IDLE: if (|req_valid) state_nxt = BUS_WAIT;
      BUS_WAIT: begin
        gnt = owner_oh;
        if (bus_free && free_cnt == FW'(BUS_FREE_CYC - 1)) state_nxt = ISSUE;
      end
      ISSUE: begin
        gnt       = owner_oh;
        eng_start = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        gnt       = owner_oh;
        eng_abort = timeout;
        if (eng_done || timeout) state_nxt = RESPOND;
      end
      RESPOND: begin
        gnt       = owner_oh;
        rsp_done  = owner_oh;
        rsp_err   = res_err;
        rsp_rdata = res_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      free_cnt    <= '0;
      owner       <= 1'b0;
      last_served <= 1'b1;
      eng_rw      <= 1'b0;
      eng_addr    <= 7'h00;
      eng_wdata   <= 8'h00;
      res_err     <= 1'b0;
      res_rdata   <= 8'h00;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (|req_valid) begin
          owner     <= pick;
          eng_rw    <= req_rw[pick];
          eng_addr  <= pick ? req_addr[13:7] : req_addr[6:0];
          eng_wdata <= pick ? req_wdata[15:8] : req_wdata[7:0];
          free_cnt  <= '0;
        end
        BUS_WAIT: begin
          if (!bus_free) free_cnt <= '0;
          else if (free_cnt != FW'(BUS_FREE_CYC)) free_cnt <= free_cnt + FW'(1);
        end
        WAIT_DONE: begin
          // A completion in the same cycle as the timeout takes priority.
          if (eng_done) begin
            res_err   <= eng_ack_err;
            res_rdata <= (eng_rw && !eng_ack_err) ? eng_rdata : 8'h00;
          end else if (timeout) begin
            res_err   <= 1'b1;
            res_rdata <= 8'h00;
          end
        end
        RESPOND: last_served <= owner;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state != WAIT_DONE) wd_cnt <= '0;
    else if (WDOG_EN && wd_cnt != TW'(TIMEOUT_CYC)) wd_cnt <= wd_cnt + TW'(1);
  end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: transaction-level reference model compared every cycle, plus directed literal checks.
module tb_i2c_master_arbiter;
  localparam int B  = 250;
  localparam int TO = 1000;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] req_valid, req_rw;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0] gnt, rsp_done;
  logic rsp_err;
  logic [7:0] rsp_rdata;
  logic scl_in, sda_in;
  logic eng_start, eng_rw;
  logic [6:0] eng_addr;
  logic [7:0] eng_wdata;
  logic eng_done, eng_ack_err;
  logic [7:0] eng_rdata;
  logic eng_abort;

  int nvec = 0, nerr = 0;
  bit chk_en = 1'b0;
  bit eng_silent = 1'b0, eng_force = 1'b0;
  logic force_ack = 1'b0;
  logic [7:0] force_rdata = 8'h00;

  always #10 clk = ~clk;

  i2c_master_arbiter #(.BUS_FREE_CYC(B), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .scl_in(scl_in), .sda_in(sda_in), .eng_start(eng_start), .eng_rw(eng_rw), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_done(eng_done), .eng_ack_err(eng_ack_err), .eng_rdata(eng_rdata),
    .eng_abort(eng_abort));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is granted, waits for B free cycles in a row, issues,
  // waits for the engine (or the watchdog), then responds for one cycle.
  bit m_busy, m_resp, m_started, m_last;
  int m_owner, m_free, m_wd;
  logic m_rw, m_err;
  logic [6:0] m_addr;
  logic [7:0] m_wdata, m_rd;
  logic [1:0] m_oh;
  logic exp_abort;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_resp = 0; m_started = 0; m_last = 1; m_owner = 0;
      m_rw = 0; m_addr = 0; m_wdata = 0; m_err = 0; m_rd = 0; m_free = 0; m_wd = 0;
    end else if (m_resp) begin
      m_resp = 0; m_busy = 0; m_last = (m_owner == 1);
    end else if (!m_busy) begin
      if (req_valid != 2'b00) begin
        if (req_valid == 2'b11) m_owner = m_last ? 0 : 1;
        else m_owner = req_valid[1] ? 1 : 0;
        m_rw = req_rw[m_owner];
        m_addr = req_addr[m_owner*7 +: 7];
        m_wdata = req_wdata[m_owner*8 +: 8];
        m_busy = 1; m_free = 0; m_started = 0; m_wd = 0;
      end
    end else if (m_free < B) begin
      m_free = (scl_in && sda_in) ? m_free + 1 : 0;
    end else if (!m_started) begin
      m_started = 1; m_wd = 0;
    end else if (eng_done) begin
      m_resp = 1; m_err = eng_ack_err;
      m_rd = (m_rw && !eng_ack_err) ? eng_rdata : 8'h00;
    end
`ifdef I2C_ARB_TIMEOUT_EN
    else begin
      m_wd++;
      if (m_wd == TO) begin m_resp = 1; m_err = 1; m_rd = 8'h00; end
    end
`endif
  end

  always @(negedge clk) begin
    if (chk_en) begin
      m_oh = (m_owner == 1) ? 2'b10 : 2'b01;
`ifdef I2C_ARB_TIMEOUT_EN
      exp_abort = m_busy && m_started && !m_resp && (m_wd == TO - 1) && !eng_done;
`else
      exp_abort = 1'b0;
`endif
      chk("gnt", 32'(gnt), 32'(m_busy ? m_oh : 2'b00));
      chk("rsp_done", 32'(rsp_done), 32'(m_resp ? m_oh : 2'b00));
      chk("rsp_err", 32'(rsp_err), 32'(m_resp && m_err));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(m_resp ? m_rd : 8'h00));
      chk("eng_start", 32'(eng_start), 32'(m_busy && !m_resp && m_free == B && !m_started));
      chk("eng_abort", 32'(eng_abort), 32'(exp_abort));
      chk("eng_rw", 32'(eng_rw), 32'(m_rw));
      chk("eng_addr", 32'(eng_addr), 32'(m_addr));
      chk("eng_wdata", 32'(eng_wdata), 32'(m_wdata));
    end
  end

  // Engine stand-in: answers each command after a random delay; emits stray eng_done while idle.
  initial begin
    eng_done = 0; eng_ack_err = 0; eng_rdata = 0;
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1 && !eng_silent) begin
        repeat ($urandom_range(1, 12)) @(posedge clk);
        #1;
        eng_done = 1;
        eng_ack_err = eng_force ? force_ack : ($urandom_range(0, 3) == 0);
        eng_rdata = eng_force ? force_rdata : 8'($urandom);
        @(posedge clk); #1;
        eng_done = 0; eng_ack_err = 1'($urandom); eng_rdata = 8'($urandom);
      end else if (gnt === 2'b00 && $urandom_range(0, 99) == 0) begin
        @(posedge clk); #1;
        eng_done = 1; eng_ack_err = 1'($urandom); eng_rdata = 8'($urandom);
        @(posedge clk); #1;
        eng_done = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input int budget, output logic [1:0] d, output bit ok);
    ok = 0; d = 2'b00;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_done != 2'b00) begin d = rsp_done; ok = 1; return; end
    end
  endtask

  task automatic count_to_start(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (eng_start) return;
      n++;
    end
  endtask

  task automatic count_to_abort(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (eng_abort) return;
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    logic [1:0] d;
    bit ok;
    int n, served;
    logic [1:0] drop;

    reset = 1; req_valid = 0; req_rw = 0; req_addr = 0; req_wdata = 0; scl_in = 1; sda_in = 1;
    tick();
    chk_en = 1;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rsp_done", 32'(rsp_done), 0);
    chk("rst_eng_start", 32'(eng_start), 0);
    chk("rst_eng_addr", 32'(eng_addr), 0);
    chk("rst_eng_abort", 32'(eng_abort), 0);
    tick();
    reset = 0;

    // Port 0 write 0x27 <- 0xA5 on an idle bus.
    eng_force = 1; force_ack = 0; force_rdata = 8'h5A;
    req_valid = 2'b01; req_rw = 2'b00; req_addr = {7'h11, 7'h27}; req_wdata = {8'h33, 8'hA5};
    @(negedge clk);
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h1);
    count_to_start(400, n);
    chk("t1_start_latency", n, 249);
    chk("t1_addr", 32'(eng_addr), 32'h27);
    chk("t1_wdata", 32'(eng_wdata), 32'hA5);
    chk("t1_rw", 32'(eng_rw), 0);
    wait_rsp(100, d, ok);
    chk("t1_rsp_seen", 32'(ok), 1);
    chk("t1_rsp_done", 32'(d), 32'h1);
    chk("t1_rsp_err", 32'(rsp_err), 0);
    chk("t1_rsp_rdata", 32'(rsp_rdata), 0);
    tick();
    req_valid = 0; eng_force = 0;

    // Both ports read from reset: 0 then 1, then 0 again on the next tie.
    reset = 1; tick(); reset = 0;
    req_valid = 2'b11; req_rw = 2'b11; req_addr = {7'h48, 7'h50};
    @(negedge clk);
    @(negedge clk);
    chk("t2_first_gnt", 32'(gnt), 32'h1);
    wait_rsp(600, d, ok);
    chk("t2_first_done", 32'(d), 32'h1);
    tick();
    req_valid = 2'b10;
    @(negedge clk);
    chk("t2_idle_gap", 32'(gnt), 0);
    @(negedge clk);
    chk("t2_second_gnt", 32'(gnt), 32'h2);
    wait_rsp(600, d, ok);
    chk("t2_second_done", 32'(d), 32'h2);
    tick();
    req_valid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("t2_third_gnt", 32'(gnt), 32'h1);
    wait_rsp(600, d, ok);
    tick();
    req_valid = 2'b10;
    wait_rsp(700, d, ok);
    chk("t2_fourth_done", 32'(d), 32'h2);
    tick();
    req_valid = 0;

    // sda held low for 100 cycles of BUS_WAIT.
    req_valid = 2'b10; req_rw = 2'b00; sda_in = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t3_gnt", 32'(gnt), 32'h2);
    repeat (100) @(posedge clk);
    #1 sda_in = 1;
    count_to_start(400, n);
    chk("t3_start_after_release", n, 250);
    wait_rsp(100, d, ok);
    chk("t3_done", 32'(d), 32'h2);
    tick();
    req_valid = 0;

    // Port 1 read answered with NACK and junk data.
    eng_force = 1; force_ack = 1; force_rdata = 8'h3C;
    req_valid = 2'b10; req_rw = 2'b10;
    wait_rsp(600, d, ok);
    chk("t4_done", 32'(d), 32'h2);
    chk("t4_err", 32'(rsp_err), 1);
    chk("t4_rdata", 32'(rsp_rdata), 0);
    tick();
    req_valid = 0; eng_force = 0;

    // Silent engine.
    eng_silent = 1;
    req_valid = 2'b01; req_rw = 2'b01;
    count_to_start(400, n);
`ifdef I2C_ARB_TIMEOUT_EN
    count_to_abort(TO + 50, n);
    chk("t5_abort_latency", n, 999);
    wait_rsp(5, d, ok);
    chk("t5_done", 32'(d), 32'h1);
    chk("t5_err", 32'(rsp_err), 1);
    chk("t5_rdata", 32'(rsp_rdata), 0);
    tick();
    req_valid = 0;
`else
    wait_rsp(TO + 200, d, ok);
    chk("t5_no_response", 32'(ok), 0);
    reset = 1; req_valid = 0; tick(); reset = 0;
`endif

    // Reset during WAIT_DONE, then a normal transaction.
    req_valid = 2'b10; req_rw = 2'b00;
    count_to_start(400, n);
    repeat (5) @(negedge clk);
    tick();
    reset = 1;
    tick();
    reset = 0; req_valid = 0;
    @(negedge clk);
    chk("t6_gnt_cleared", 32'(gnt), 0);
    chk("t6_addr_cleared", 32'(eng_addr), 0);
    chk("t6_abort_low", 32'(eng_abort), 0);
    eng_silent = 0;
    tick();
    req_valid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("t6_gnt_port0", 32'(gnt), 32'h1);
    wait_rsp(600, d, ok);
    chk("t6_done", 32'(d), 32'h1);
    tick();
    req_valid = 2'b10;
    wait_rsp(700, d, ok);
    tick();
    req_valid = 0;

    // Randomized traffic with bus glitches and fields that change after grant.
    served = 0;
    for (int c = 0; c < 40000 && served < 50; c++) begin
      @(negedge clk);
      drop = rsp_done;
      if (rsp_done != 2'b00) served++;
      @(posedge clk); #1;
      req_valid = req_valid & ~drop;
      for (int p = 0; p < 2; p++) begin
        if (gnt[p] && $urandom_range(0, 199) == 0) req_valid[p] = 1'b0;
        else if (!req_valid[p] && gnt == 2'b00 && $urandom_range(0, 19) == 0) req_valid[p] = 1'b1;
      end
      req_rw = 2'($urandom); req_addr = 14'($urandom); req_wdata = 16'($urandom);
      if (!scl_in || !sda_in) begin
        scl_in = 1; sda_in = 1;
      end else if ($urandom_range(0, 299) == 0) begin
        if ($urandom_range(0, 1) == 1) scl_in = 0; else sda_in = 0;
      end
    end
    chk("rand_served", 32'(served >= 50), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Two-port round-robin scheduler that shares one byte-level I2C master engine between requesters, e.g. the rotary/LCD menu action path (port 0) and a periodic button/switch poller (port 1). It serialises single-byte read/write transactions, waits for the open-drain bus to be idle, issues one engine command per grant and returns read data or error status to the winning requester. It sits between the user-interface logic and the engine that drives the pulled-up scl/sda lines.

## Interface
- BUS_FREE_CYC, 250, consecutive cycles scl_in and sda_in must both be high before a command is issued (5 µs at 50 MHz)
- TIMEOUT_CYC, 2_500_000, engine watchdog limit in cycles (50 ms at 50 MHz); used only with I2C_ARB_TIMEOUT_EN
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high; one clock, reset synchronous active-high
- req_valid  in  2  per-port request; held until that port's rsp_done
- req_rw  in  2  per-port direction: 1 = read, 0 = write
- req_addr  in  14  port0 = [6:0], port1 = [13:7]; 7-bit slave address
- req_wdata  in  16  port0 = [7:0], port1 = [15:8]
- gnt  out  2  one-hot, current owner
- rsp_done  out  2  one-cycle completion pulse to owner
- rsp_err  out  1  NACK or timeout; valid with rsp_done
- rsp_rdata  out  8  read byte; valid with rsp_done; 0 on write or error
- scl_in, sda_in  in  1 each  sampled bus lines, already synchronised
- eng_start  out  1  one-cycle command strobe
- eng_rw  out  1; eng_addr  out  7; eng_wdata  out  8  command fields, stable from eng_start until eng_done
- eng_done  in  1  engine completion pulse
- eng_ack_err  in  1  NACK flag, valid with eng_done
- eng_rdata  in  8  read byte, valid with eng_done
- eng_abort  out  1  one-cycle abort strobe on timeout

## Operation
- States: IDLE, BUS_WAIT, ISSUE, WAIT_DONE, RESPOND.
- IDLE: if any req_valid, choose winner. If only one port requests, it wins. If both request, the port not served last wins. Latch the winner's rw, addr and wdata. Set gnt and go to BUS_WAIT with the free counter cleared.
- BUS_WAIT: the free counter increments on each cycle with scl_in and sda_in both high. It clears to 0 on any cycle where either line is low. When it reaches BUS_FREE_CYC, go to ISSUE.
- ISSUE: assert eng_start for exactly one cycle with the latched fields, then go to WAIT_DONE with the watchdog cleared.
- WAIT_DONE: on eng_done, capture eng_rdata (forced to 0 for writes or when eng_ack_err = 1) and eng_ack_err, then go to RESPOND.
- RESPOND: pulse rsp_done[owner] for one cycle, present rsp_err and rsp_rdata, update last-served to the owner, clear gnt and return to IDLE.
- Requests are latched at grant. Deasserting or changing req_valid or request fields after grant has no effect; the transaction completes and rsp_done still pulses.
- eng_done outside WAIT_DONE is ignored.

## Timing
- Reset values: gnt = 0, rsp_done = 0, rsp_err = 0, rsp_rdata = 0, eng_start = 0, eng_abort = 0, eng_rw = 0, eng_addr = 0, eng_wdata = 0. Last-served resets to port 1, so port 0 wins the first tie.
- Grant latency: req_valid sampled in IDLE at edge N gives gnt at N+1.
- With the bus continuously free, eng_start is high in cycle N+1+BUS_FREE_CYC.
- rsp_done is asserted the cycle after eng_done is sampled.
- There is exactly one IDLE cycle between consecutive transactions.
- Reset asserted mid-transaction: all outputs return to reset values at the next edge and no eng_abort is issued. The engine shares the same reset.
- Counter widths: ceil(log2(max+1)) of the respective parameter. Counters saturate and never wrap.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - In WAIT_DONE the watchdog counts every cycle.
  - On reaching TIMEOUT_CYC without eng_done, eng_abort pulses for one cycle and the block enters RESPOND with rsp_err = 1 and rsp_rdata = 0.
  - If eng_done and the timeout occur in the same cycle, eng_done wins.
- I2C_ARB_TIMEOUT_EN undefined: no watchdog. eng_abort is tied to 0 and WAIT_DONE waits indefinitely for eng_done.

## Test plan
- Port0 write, addr 0x27, data 0xA5, bus idle -> gnt = 01 next cycle; eng_start after BUS_FREE_CYC cycles with addr 0x27, wdata 0xA5, rw 0; engine done with no NACK -> rsp_done = 01, rsp_err = 0, rsp_rdata = 0.
- Both ports request reads from reset -> port0 served first, then port1 after one IDLE cycle. Next simultaneous request -> port0 served first again (round-robin alternates).
- sda_in held low for 100 cycles during BUS_WAIT -> no eng_start until BUS_FREE_CYC consecutive free cycles after release.
- Port1 read, engine returns eng_rdata = 0x3C with eng_ack_err = 1 -> rsp_done = 10, rsp_err = 1, rsp_rdata = 0x00.
- I2C_ARB_TIMEOUT_EN defined with TIMEOUT_CYC = 1000, engine silent -> eng_abort pulse at cycle 1000 of WAIT_DONE, then rsp_err = 1. Same stimulus with the macro undefined -> no abort and no response.
- Reset asserted during WAIT_DONE -> all outputs 0 next cycle; a later request is served normally by port 0.
